// File: rtl/logic_ctrl_pkg.sv
// logic_ctrl_pkg: shared state encoding, defaults and output decode
// for the matrix-multiply job sequencer.
package logic_ctrl_pkg;

    localparam int N_ROWS_DEF     = 4;
    localparam int N_MUL_DEF      = 8;
    localparam int WB_TIMEOUT_DEF = 16;
    localparam int ROW_W          = $clog2(N_ROWS_DEF);
    localparam int MUL_W          = $clog2(N_MUL_DEF);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_KICK    = 3'd2,
        S_COMPUTE = 3'd3,
        S_WB_REQ  = 3'd4,
        S_WB_WAIT = 3'd5,
        S_AVGMAX  = 3'd6,
        S_FIN     = 3'd7
    } state_e;

    typedef struct packed {
        logic busy;
        logic in_ready;
        logic input_load_en;
        logic rom_start;
        logic au_en;
        logic web;
        logic avgmax_en;
        logic done;
    } ctrl_out_t;

    function automatic ctrl_out_t decode_outs(state_e s);
        ctrl_out_t o;
        o      = '0;
        o.busy = (s != S_IDLE);
        unique case (s)
            S_LOAD: begin
                o.input_load_en = 1'b1;
                o.in_ready      = 1'b1;
            end
            S_KICK:    o.rom_start = 1'b1;
            S_COMPUTE: o.au_en     = 1'b1;
            S_WB_REQ:  o.web       = 1'b1;
            S_AVGMAX:  o.avgmax_en = 1'b1;
            S_FIN:     o.done      = 1'b1;
            default:   ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ctrl_counter.sv
// ctrl_counter: clearable, enable-gated saturating up-counter.
// tc_o is high while the count sits at LIMIT.
module ctrl_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == W'(LIMIT));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/logic_ctrl.sv
// logic_ctrl: per-job sequencer for the matmul datapath
// (X load, per-row ROM kick / MAC / writeback, then avg/max).
module logic_ctrl
    import logic_ctrl_pkg::*;
#(
    parameter int N_ROWS     = N_ROWS_DEF,
    parameter int N_MUL      = N_MUL_DEF,
    parameter int WB_TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             valid_input,
    output logic             in_ready,
    input  logic             xload_done,
    input  logic [MUL_W-1:0] count_mul,
    input  logic             ram_done,
    output logic             input_load_en,
    output logic             rom_start,
    output logic             AU_en,
    output logic             web,
    output logic [ROW_W-1:0] row_idx,
    output logic             avgmax_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
    localparam int AV_W  = $clog2(N_ROWS + 1);

    state_e           state_q, state_d;
    ctrl_out_t        out_q;
    logic             err_q, err_d;
    logic [MUL_W-1:0] cm_prev_q;

    logic             row_clr, row_en, row_tc;
    logic [ROW_W-1:0] row_cnt;
    logic             tmo_clr, tmo_en, tmo_tc;
    logic [TMO_W-1:0] tmo_cnt;
    logic             av_clr, av_en, av_tc;
    logic [AV_W-1:0]  av_cnt;

    logic             mul_hit, tmo_hit, av_last;

    // Byte qualification lives in the X buffer; only in_ready is ours.
    logic             unused_valid;
    assign unused_valid = valid_input;

    // Edge-detect so a count left at N_MUL-1 from before doesn't end the row.
    assign mul_hit = (count_mul == MUL_W'(N_MUL - 1))
                  && (cm_prev_q != MUL_W'(N_MUL - 1));
    assign tmo_hit = tmo_tc || (tmo_cnt == TMO_W'(WB_TIMEOUT - 1));
    assign av_last = av_tc || (av_cnt == AV_W'(N_ROWS - 1));

    ctrl_counter #(.W(ROW_W), .LIMIT(N_ROWS - 1)) u_row_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (row_clr),
        .en_i  (row_en),
        .cnt_o (row_cnt),
        .tc_o  (row_tc)
    );

    ctrl_counter #(.W(TMO_W), .LIMIT(WB_TIMEOUT)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmo_clr),
        .en_i  (tmo_en),
        .cnt_o (tmo_cnt),
        .tc_o  (tmo_tc)
    );

    ctrl_counter #(.W(AV_W), .LIMIT(N_ROWS)) u_av_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (av_clr),
        .en_i  (av_en),
        .cnt_o (av_cnt),
        .tc_o  (av_tc)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        row_clr = 1'b0;
        row_en  = 1'b0;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        av_clr  = 1'b0;
        av_en   = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            row_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        row_clr = 1'b1;
                        av_clr  = 1'b1;
                        err_d   = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (xload_done) state_d = S_KICK;
                end
                S_KICK: state_d = S_COMPUTE;
                S_COMPUTE: begin
                    if (mul_hit) state_d = S_WB_REQ;
                end
                S_WB_REQ: begin
                    tmo_clr = 1'b1;
                    state_d = S_WB_WAIT;
                end
                S_WB_WAIT: begin
                    tmo_en = 1'b1;
                    if (ram_done) begin
                        if (row_tc) begin
                            state_d = S_AVGMAX;
                        end else begin
                            row_en  = 1'b1;
                            state_d = S_KICK;
                        end
                    end else if (tmo_hit) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
                S_AVGMAX: begin
                    av_en = 1'b1;
                    if (av_last) state_d = S_FIN;
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            out_q     <= '0;
            err_q     <= 1'b0;
            cm_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= decode_outs(state_d);
            err_q     <= err_d;
            cm_prev_q <= count_mul;
        end
    end

    assign busy          = out_q.busy;
    assign in_ready      = out_q.in_ready;
    assign input_load_en = out_q.input_load_en;
    assign rom_start     = out_q.rom_start;
    assign AU_en         = out_q.au_en;
    assign web           = out_q.web;
    assign avgmax_en     = out_q.avgmax_en;
    assign done          = out_q.done;
    assign err           = err_q;
    assign row_idx       = row_cnt;

endmodule

// File: tb/tb_logic_ctrl.sv
// tb_logic_ctrl: directed cycle-accurate checks of the job sequencer.
module tb_logic_ctrl;

    logic       clk;
    logic       rst;
    logic       start, abort, valid_input, xload_done, ram_done;
    logic [2:0] count_mul;
    logic       in_ready, input_load_en, rom_start, AU_en, web;
    logic       avgmax_en, busy, done, err;
    logic [1:0] row_idx;

    int total = 0;
    int bad   = 0;
    int n_rom = 0, n_web = 0, n_avg = 0, n_done = 0;
    int s_rom, s_web, s_avg, s_done;
    int outs, row_i;

    // bit order: busy in_ready ld rom au web avg done err
    localparam int K_IDLE     = 'b000000000;
    localparam int K_IDLE_ERR = 'b000000001;
    localparam int K_LOAD     = 'b111000000;
    localparam int K_KICK     = 'b100100000;
    localparam int K_COMP     = 'b100010000;
    localparam int K_WEB      = 'b100001000;
    localparam int K_WAIT     = 'b100000000;
    localparam int K_AVG      = 'b100000100;
    localparam int K_FIN      = 'b100000010;
    localparam int K_FIN_ERR  = 'b100000011;

    assign outs = {23'd0, busy, in_ready, input_load_en, rom_start,
                   AU_en, web, avgmax_en, done, err};
    assign row_i = {30'd0, row_idx};

    logic_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .valid_input   (valid_input),
        .in_ready      (in_ready),
        .xload_done    (xload_done),
        .count_mul     (count_mul),
        .ram_done      (ram_done),
        .input_load_en (input_load_en),
        .rom_start     (rom_start),
        .AU_en         (AU_en),
        .web           (web),
        .row_idx       (row_idx),
        .avgmax_en     (avgmax_en),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rom_start) n_rom++;
        if (web) n_web++;
        if (avgmax_en) n_avg++;
        if (done) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_rom  = n_rom;
        s_web  = n_web;
        s_avg  = n_avg;
        s_done = n_done;
    endtask

    task automatic start_job();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("load", outs, K_LOAD);
        chk("load_row", row_i, 0);
        for (int i = 1; i < 32; i++) begin
            valid_input = i[0];
            start = (i == 10);
            cyc();
        end
        start = 1'b0;
        valid_input = 1'b1;
        chk("load_hold", outs, K_LOAD);
        xload_done = 1'b1;
        cyc();
        xload_done = 1'b0;
    endtask

    // mode: 0 nominal, 1 ram_done withheld, 2 abort in COMPUTE
    task automatic do_row(input int r, input bit stale, input int mode);
        chk("kick", outs, K_KICK);
        chk("kick_row", row_i, r);
        count_mul = stale ? 3'd7 : 3'd0;
        cyc();
        if (stale) begin
            for (int i = 0; i < 3; i++) begin
                chk("stale_hold", outs, K_COMP);
                cyc();
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (mode == 2 && k == 3) begin
                abort = 1'b1;
                cyc();
                abort = 1'b0;
                chk("abort_idle", outs, K_IDLE);
                chk("abort_row", row_i, 0);
                return;
            end
            count_mul = 3'(k);
            chk("compute", outs, K_COMP);
            cyc();
        end
        chk("web", outs, K_WEB);
        chk("web_row", row_i, r);
        count_mul = 3'd0;
        cyc();
        if (mode == 1) begin
            for (int d = 1; d <= 16; d++) begin
                chk("tmo_wait", outs, K_WAIT);
                cyc();
            end
            chk("tmo_fin", outs, K_FIN_ERR);
            return;
        end
        chk("wait1", outs, K_WAIT);
        cyc();
        chk("wait2", outs, K_WAIT);
        ram_done = 1'b1;
        cyc();
        ram_done = 1'b0;
    endtask

    task automatic run_job(input int stale_row, input int drop_row,
                           input int abort_row, input bit rst_avg);
        start_job();
        for (int r = 0; r < 4; r++) begin
            do_row(r, r == stale_row,
                   r == drop_row ? 1 : (r == abort_row ? 2 : 0));
            if (r == drop_row) begin
                cyc();
                chk("tmo_idle", outs, K_IDLE_ERR);
                return;
            end
            if (r == abort_row) return;
        end
        chk("avg_row", row_i, 3);
        for (int i = 0; i < 4; i++) begin
            if (rst_avg && i == 2) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_async", outs, K_IDLE);
                chk("rst_row", row_i, 0);
                cyc();
                #2 rst = 1'b1;
                cyc();
                cyc();
                chk("rst_release", outs, K_IDLE);
                return;
            end
            start = (i == 0);
            chk("avg", outs, K_AVG);
            cyc();
        end
        start = 1'b0;
        chk("fin", outs, K_FIN);
        cyc();
        chk("idle", outs, K_IDLE);
    endtask

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        valid_input = 1'b0;
        xload_done  = 1'b0;
        ram_done    = 1'b0;
        count_mul   = 3'd0;
        cyc();
        cyc();
        chk("reset_outs", outs, K_IDLE);
        chk("reset_row", row_i, 0);
        #2 rst = 1'b1;
        cyc();
        chk("idle_after_reset", outs, K_IDLE);
        valid_input = 1'b1;

        snap();
        run_job(-1, -1, -1, 1'b0);
        chk("nom_rom", n_rom - s_rom, 4);
        chk("nom_web", n_web - s_web, 4);
        chk("nom_avg", n_avg - s_avg, 4);
        chk("nom_done", n_done - s_done, 1);

        snap();
        run_job(0, -1, -1, 1'b0);
        chk("stale_web", n_web - s_web, 4);
        chk("stale_done", n_done - s_done, 1);

        snap();
        run_job(-1, 2, -1, 1'b0);
        chk("tmo_avg", n_avg - s_avg, 0);
        chk("tmo_done", n_done - s_done, 1);

        snap();
        run_job(-1, -1, 1, 1'b0);
        chk("abort_done", n_done - s_done, 0);

        snap();
        run_job(-1, -1, -1, 1'b1);
        chk("rst_done", n_done - s_done, 0);
        chk("rst_avg", n_avg - s_avg, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
